load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit that initiates every data-memory access in the reduced RISC-V core. It accepts one byte, halfword or word request at a time from the execute stage. It drives the word-addressed, write-enabled, registered-read data memory port (WE, WD, A, RD). Sub-word stores are built by read-modify-write, because the memory only writes whole words.

## Interface
- DATA_WIDTH, 32: data and byte-address width; fixed at 32 for byte-lane logic.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle; the request is accepted on an edge where req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  input  1  loads: zero-extend (1) or sign-extend (0).
- req_addr  input  DATA_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  extended load data; valid with resp_valid, holds value until the next load.
- resp_err  output  1  misaligned request (see Configuration); valid with resp_valid.
- mem_we  output  1  memory write enable.
- mem_a  output  DATA_WIDTH  word address = req_addr >> 2.
- mem_wd  output  DATA_WIDTH  memory write data.
- mem_rd  input  DATA_WIDTH  memory read data, valid the cycle after mem_a is sampled.

## Operation
- All outputs except req_ready are registered. req_ready = (state == IDLE).
- Reset values:
  - State is IDLE.
  - mem_we=0, mem_a=0, mem_wd=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1.
- The request is latched at acceptance. Inputs are ignored while req_ready=0.
- FSM states: IDLE, ACCESS, CAPTURE, WRITE.
- IDLE: on accept, load mem_a and go to ACCESS.
  - Word store: mem_we<=1 and mem_wd<=req_wdata at the same edge.
- ACCESS: memory samples mem_a (and mem_we) at the end of the cycle.
  - Word store: clear mem_we, pulse resp_valid, go to IDLE.
  - Otherwise: go to CAPTURE.
- CAPTURE: mem_rd is valid in this cycle.
  - Load: select the lane, extend, write resp_rdata, pulse resp_valid, go to IDLE.
  - Sub-word store: set mem_wd to mem_rd with the target lane replaced, set mem_we<=1, go to WRITE.
- WRITE: the memory writes at the end of the cycle. Clear mem_we, pulse resp_valid, go to IDLE.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], with k = addr[1:0];
  - halfword h = bits [16h+15:16h], with h = addr[1].
- Stores use req_wdata[7:0] or [15:0]. Loads use bit 7 or bit 15 as the sign bit.
- mem_we is never high outside a single-cycle write state.

## Timing
- Acceptance edge E0. Responses:
  - Word store: mem_we high in cycle E0-E1; resp_valid high in E1-E2.
  - Load: mem_rd valid in E1-E2; resp_valid and resp_rdata in E2-E3.
  - Sub-word store: read in E0-E1, write in E2-E3; resp_valid high in E3-E4.
- req_ready rises together with resp_valid. A new request can be accepted on the edge ending the resp_valid cycle (back-to-back, no bubble).
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - A pending RMW write is abandoned; memory keeps the old word.
  - No resp_valid is produced for the aborted request.
- Addresses wrap modulo 2^32.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Such a request skips memory entirely (mem_we stays 0).
  - It pulses resp_valid with resp_err=1 one cycle after acceptance. resp_rdata is unchanged.
- Undefined:
  - The required alignment bits are forced to 0 (halfword clears addr[0], word clears addr[1:0]).
  - The access then proceeds normally; resp_err is tied 0.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, load word 0x10 -> mem_a=4 with mem_we=1 for 1 cycle; load resp_rdata=0xDEADBEEF two cycles after accept.
- Byte store RMW: word 0x10 = 0x11223344; store byte 0xAA at 0x12 -> read then write mem_wd=0x11AA3344; resp_valid 3 cycles after accept; exactly one mem_we pulse.
- Sign extension, word 0x8001F080:
  - lb 0x00 -> 0xFFFFFF80;
  - lbu 0x00 -> 0x00000080;
  - lh 0x02 -> 0xFFFF8001;
  - lhu 0x02 -> 0x00008001.
- Back-to-back: req_valid held high with 4 loads -> each accepted on the edge ending the previous resp_valid; resp_valid pulses every 3 cycles.
- Reset during WRITE of a byte store to 0x20 (old 0x01020304) -> mem_we falls immediately; the later load returns 0x01020304; no resp_valid.
- Misaligned word load at 0x13:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1 one cycle after accept, mem_we stays 0;
  - without it: mem_a=4 and data read from word 0x10.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word access at a time to a word-addressed, registered-read memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests trap with resp_err instead of being aligned down.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, WRITE} state_e;

  state_e          state_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      off_q;
  logic [15:0]     wdata_q;
  logic            err_q;

  logic [DATA_WIDTH-1:0] addr_al;
  logic                  misaligned;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_d;
  logic [DATA_WIDTH-1:0] merge_d;

  // Alignment bits are cleared for half/word; in trap mode only aligned requests reach memory anyway.
  assign addr_al = {req_addr_i[DATA_WIDTH-1:2],
                    req_addr_i[1] & ~req_size_i[1],
                    req_addr_i[0] & ~(req_size_i[1] | req_size_i[0])};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready_o = (state_q == IDLE);

  always_comb begin
    byte_sel = mem_rd_i[7:0];
    case (off_q)
      2'd1:    byte_sel = mem_rd_i[15:8];
      2'd2:    byte_sel = mem_rd_i[23:16];
      2'd3:    byte_sel = mem_rd_i[31:24];
      default: byte_sel = mem_rd_i[7:0];
    endcase
    half_sel = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    case (size_q)
      2'b00:   load_d = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_d = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_d = mem_rd_i;
    endcase

    // Only sub-word stores reach the merge, so a non-byte size here is a halfword.
    merge_d = mem_rd_i;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd1:    merge_d[15:8]  = wdata_q[7:0];
        2'd2:    merge_d[23:16] = wdata_q[7:0];
        2'd3:    merge_d[31:24] = wdata_q[7:0];
        default: merge_d[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merge_d[31:16] = wdata_q;
    end else begin
      merge_d[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_a_o      <= '0;
      mem_wd_o     <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            off_q   <= addr_al[1:0];
            wdata_q <= req_wdata_i[15:0];
            err_q   <= misaligned;
            state_q <= ACCESS;
            if (!misaligned) begin
              mem_a_o <= {2'b00, addr_al[DATA_WIDTH-1:2]};
              if (req_we_i && req_size_i[1]) begin
                mem_we_o <= 1'b1;
                mem_wd_o <= req_wdata_i;
              end
            end
          end
        end
        ACCESS: begin
          if (err_q) begin
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            state_q      <= IDLE;
          end else if (we_q && size_q[1]) begin
            mem_we_o     <= 1'b0;
            resp_valid_o <= 1'b1;
            state_q      <= IDLE;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!we_q) begin
            resp_rdata_o <= load_d;
            resp_valid_o <= 1'b1;
            state_q      <= IDLE;
          end else begin
            mem_wd_o <= merge_d;
            mem_we_o <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          mem_we_o     <= 1'b0;
          resp_valid_o <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand sequences, and random traffic
// checked against a request-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUns;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic        memWe;
  logic [31:0] memA;
  logic [31:0] memWd;
  logic [31:0] memRd;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
    .req_size_i(reqSize), .req_unsigned_i(reqUns), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .resp_valid_o(respValid), .resp_rdata_o(respRdata),
    .resp_err_o(respErr), .mem_we_o(memWe), .mem_a_o(memA), .mem_wd_o(memWd),
    .mem_rd_i(memRd)
  );

  // Environment memory (registered read) and the reference model's view of it.
  logic [31:0] ram   [64];
  logic [31:0] model [64];

  always @(posedge clk) begin
    if (memWe) ram[memA[5:0]] <= memWd;
    memRd <= ram[memA[5:0]];
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] lastRdata = 32'h0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    int          expLat;
    logic        expErr;
  } vecT;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vecT mkVec(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expData, input int expLat, input logic expErr);
    vecT v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.expData = expData; v.expLat = expLat; v.expErr = expErr;
    return v;
  endfunction

  function automatic logic [31:0] alignAddr(input logic [1:0] size, input logic [31:0] addr);
    if (size >= 2'd2) return addr & ~32'h3;
    if (size == 2'd1) return addr & ~32'h1;
    return addr;
  endfunction

  function automatic logic isTrap(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((size == 2'd1) && addr[0]) || ((size >= 2'd2) && (addr[1:0] != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    logic [31:0] a = alignAddr(size, addr);
    logic [31:0] w = model[a[7:2]];
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!uns) v = (v ^ 32'h80) - 32'h80;
    end else if (size == 2'd1) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (!uns) v = (v ^ 32'h8000) - 32'h8000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] modelMerge(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] a = alignAddr(size, addr);
    logic [31:0] w = model[a[7:2]];
    logic [31:0] mask;
    int sh;
    if (size >= 2'd2) return wdata;
    if (size == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * int'(a[1]);
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((wdata << sh) & mask);
  endfunction

  function automatic vecT modelVec(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    vecT v = mkVec(we, size, uns, addr, wdata, 32'h0, 2, 1'b0);
    if (isTrap(size, addr)) begin
      v.expErr = 1'b1;
      v.expLat = 1;
    end else if (we) begin
      v.expLat  = (size >= 2'd2) ? 1 : 3;
      v.expData = modelMerge(size, addr, wdata);
    end else begin
      v.expData = modelLoad(size, uns, addr);
    end
    return v;
  endfunction

  // Drives one request, then scrambles the inputs so the DUT must rely on its latched copy.
  task automatic applyStimulus(input vecT v, output int lat, output int wes, output logic [31:0] rdata,
                               output logic [31:0] wd, output logic [31:0] aResp, output logic err);
    lat = -1; wes = 0; rdata = 0; wd = 0; aResp = 0; err = 0;
    @(negedge clk);
    checkOutput("readyIdle", {31'b0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWe = v.we; reqSize = v.size; reqUns = v.uns;
    reqAddr = v.addr; reqWdata = v.wdata;
    @(posedge clk); #1;
    reqValid = 1'b0; reqWe = 1'($urandom); reqSize = 2'($urandom); reqUns = 1'($urandom);
    reqAddr = $urandom; reqWdata = $urandom;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (memWe) begin
        wes++;
        wd = memWd;
      end
      if (respValid) begin
        lat = k; rdata = respRdata; err = respErr; aResp = memA;
        checkOutput("readyWithResp", {31'b0, reqReady}, 32'd1);
        break;
      end
    end
  endtask

  task automatic runVec(input vecT v, input string tag);
    int lat, wes;
    logic [31:0] rdata, wd, aResp;
    logic err;
    applyStimulus(v, lat, wes, rdata, wd, aResp, err);
    if (lat < 0) begin
      checkOutput({tag, "Timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "Latency"}, lat, v.expLat);
    checkOutput({tag, "Err"}, {31'b0, err}, {31'b0, v.expErr});
    if (v.expErr) begin
      checkOutput({tag, "WePulses"}, wes, 32'd0);
      checkOutput({tag, "RdataHeld"}, rdata, lastRdata);
    end else begin
      checkOutput({tag, "MemA"}, aResp, alignAddr(v.size, v.addr) >> 2);
      if (v.we) begin
        checkOutput({tag, "WePulses"}, wes, 32'd1);
        checkOutput({tag, "WriteData"}, wd, v.expData);
        model[(v.addr >> 2) & 32'h3F] = v.expData;
      end else begin
        checkOutput({tag, "WePulses"}, wes, 32'd0);
        checkOutput({tag, "Rdata"}, rdata, v.expData);
        lastRdata = v.expData;
      end
    end
  endtask

  initial begin
    vecT vecs[$];
    vecT v;
    vecT bb[4];
    int sawWe, sawResp, issued, got, prevCyc;

    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      model[i] = ram[i];
    end
    rstN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'd0; reqUns = 1'b0;
    reqAddr = 32'h0; reqWdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", {31'b0, reqReady}, 32'd1);
    checkOutput("rstRespValid", {31'b0, respValid}, 32'd0);
    checkOutput("rstRdata", respRdata, 32'd0);
    checkOutput("rstErr", {31'b0, respErr}, 32'd0);
    checkOutput("rstMemWe", {31'b0, memWe}, 32'd0);
    checkOutput("rstMemA", memA, 32'd0);
    checkOutput("rstMemWd", memWd, 32'd0);
    rstN = 1'b1;

    // we, size, uns, addr, wdata, expected data (written word or load result), latency, err
    vecs.push_back(mkVec(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mkVec(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 0));
    vecs.push_back(mkVec(1, 2'd2, 0, 32'h10, 32'h11223344, 32'h11223344, 1, 0));
    vecs.push_back(mkVec(1, 2'd0, 0, 32'h12, 32'h123456AA, 32'h11AA3344, 3, 0));
    vecs.push_back(mkVec(0, 2'd2, 0, 32'h10, 32'h0,        32'h11AA3344, 2, 0));
    vecs.push_back(mkVec(1, 2'd2, 0, 32'h00, 32'h8001F080, 32'h8001F080, 1, 0));
    vecs.push_back(mkVec(0, 2'd0, 0, 32'h00, 32'h0,        32'hFFFFFF80, 2, 0));
    vecs.push_back(mkVec(0, 2'd0, 1, 32'h00, 32'h0,        32'h00000080, 2, 0));
    vecs.push_back(mkVec(0, 2'd1, 0, 32'h02, 32'h0,        32'hFFFF8001, 2, 0));
    vecs.push_back(mkVec(0, 2'd1, 1, 32'h02, 32'h0,        32'h00008001, 2, 0));
    vecs.push_back(mkVec(1, 2'd2, 0, 32'h04, 32'h55667788, 32'h55667788, 1, 0));
    vecs.push_back(mkVec(1, 2'd1, 0, 32'h06, 32'hFFFFCAFE, 32'hCAFE7788, 3, 0));
    vecs.push_back(mkVec(0, 2'd2, 0, 32'h04, 32'h0,        32'hCAFE7788, 2, 0));
    vecs.push_back(mkVec(0, 2'd0, 0, 32'h07, 32'h0,        32'hFFFFFFCA, 2, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mkVec(0, 2'd2, 0, 32'h13, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mkVec(0, 2'd1, 0, 32'h03, 32'h0,        32'h0,        1, 1));
`else
    vecs.push_back(mkVec(0, 2'd2, 0, 32'h13, 32'h0,        32'h11AA3344, 2, 0));
    vecs.push_back(mkVec(0, 2'd1, 0, 32'h03, 32'h0,        32'hFFFF8001, 2, 0));
`endif
    vecs.push_back(mkVec(0, 2'd3, 0, 32'h10, 32'h0,        32'h11AA3344, 2, 0));

    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted during the write cycle of a byte RMW: the old word must survive.
    runVec(mkVec(1, 2'd2, 0, 32'h20, 32'h01020304, 32'h01020304, 1, 0), "rstPre");
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'd0; reqUns = 1'b0;
    reqAddr = 32'h21; reqWdata = 32'h000000FF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    sawWe = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (memWe) begin
        sawWe = k;
        break;
      end
    end
    checkOutput("rmwWriteCycle", sawWe, 32'd2);
    rstN = 1'b0;
    #1;
    checkOutput("abortMemWe", {31'b0, memWe}, 32'd0);
    checkOutput("abortRespValid", {31'b0, respValid}, 32'd0);
    checkOutput("abortReady", {31'b0, reqReady}, 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    sawResp = 0;
    repeat (5) begin
      @(negedge clk);
      if (respValid) sawResp++;
    end
    checkOutput("abortNoResp", sawResp, 32'd0);
    runVec(mkVec(0, 2'd2, 0, 32'h20, 32'h0, 32'h01020304, 2, 0), "rstPost");

    // Back-to-back loads with req_valid held high.
    bb[0] = modelVec(0, 2'd2, 0, 32'h10, 32'h0);
    bb[1] = modelVec(0, 2'd0, 1, 32'h11, 32'h0);
    bb[2] = modelVec(0, 2'd1, 0, 32'h06, 32'h0);
    bb[3] = modelVec(0, 2'd2, 0, 32'h20, 32'h0);
    issued = 0; got = 0; prevCyc = -1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (respValid) begin
        checkOutput($sformatf("b2bData%0d", got), respRdata, bb[got].expData);
        if (got > 0) checkOutput("b2bSpacing", cyc - prevCyc, 32'd3);
        prevCyc = cyc;
        got++;
      end
      if (got < 4 && reqReady && issued < 4) begin
        reqValid = 1'b1; reqWe = bb[issued].we; reqSize = bb[issued].size;
        reqUns = bb[issued].uns; reqAddr = bb[issued].addr; reqWdata = bb[issued].wdata;
        issued++;
      end
    end
    reqValid = 1'b0;
    checkOutput("b2bCount", got, 32'd4);
    lastRdata = bb[3].expData;

    // Random traffic within the modelled 256-byte window.
    for (int i = 0; i < 200; i++) begin
      v = modelVec(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom);
      runVec(v, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
